// File: rtl/fifo_generator_pkg.sv
// fifo_generator_pkg
//    Shared defaults for the 6-bit-in / 3-bit-out packet-count FIFO.
//    DIN_W_DEF  : write word width
//    DOUT_W_DEF : read nibble width (DIN_W must be 2*DOUT_W)
//    DEPTH_DEF  : capacity in write words (power of two)
//    PTR_W_DEF  : nibble pointer width, $clog2(2*DEPTH)
package fifo_generator_pkg;

   localparam int unsigned DIN_W_DEF  = 6;
   localparam int unsigned DOUT_W_DEF = 3;
   localparam int unsigned DEPTH_DEF  = 16;

   function automatic int unsigned nib_ptr_w(input int unsigned depth);
      return $clog2(2 * depth);
   endfunction

   localparam int unsigned PTR_W_DEF = nib_ptr_w(DEPTH_DEF);

endpackage

// File: rtl/fifo_generator_ram.sv
// fifo_generator_ram
//    DOUT_W-wide, 2*DEPTH-deep simple dual-port RAM built from two banks.
//    The even bank holds the MSB nibble of each word and the odd bank the
//    LSB nibble, so one write stores a whole word at a shared word address.
//    Ports:
//       clk      : clock (rising edge)
//       rst      : synchronous active-high reset of the read register
//       we       : write enable
//       waddr    : word address (nibble address / 2)
//       wdata_hi : nibble for the even slot
//       wdata_lo : nibble for the odd slot
//       re       : read enable; rdata holds when low
//       raddr    : nibble address
//       rdata    : registered read data
module fifo_generator_ram
   import fifo_generator_pkg::*;
#(
   parameter int unsigned DOUT_W = DOUT_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [DOUT_W-1:0]          wdata_hi,
   input  logic [DOUT_W-1:0]          wdata_lo,
   input  logic                       re,
   input  logic [$clog2(DEPTH):0]     raddr,
   output logic [DOUT_W-1:0]          rdata
);

   localparam int unsigned AW = $clog2(DEPTH);

   logic [DOUT_W-1:0] mem_even_q [DEPTH];
   logic [DOUT_W-1:0] mem_odd_q  [DEPTH];
   logic [DOUT_W-1:0] rdata_q;
   logic [DOUT_W-1:0] rdata_d;

   // Storage has no reset; contents are only meaningful behind the pointers.
   always_ff @(posedge clk) begin
      if (we) begin
         mem_even_q[waddr] <= wdata_hi;
         mem_odd_q[waddr]  <= wdata_lo;
      end
   end

   always_comb begin
      rdata_d = rdata_q;
      if (re) begin
         rdata_d = raddr[0] ? mem_odd_q[raddr[AW:1]] : mem_even_q[raddr[AW:1]];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/fifo_generator.sv
// fifo_generator
//    Synchronous FIFO: 6-bit words in, 3-bit nibbles out, MSB nibble first.
//    Standard (non-FWFT) read mode, one-cycle read latency, all outputs
//    registered.
//    Ports:
//       wr_clk : the single clock (rising edge)
//       rd_clk : compatibility only, tie to wr_clk; unused
//       rst    : synchronous active-high reset
//       wr_en  : write request, dropped while full
//       din    : write word
//       wr_ack : one-cycle pulse after an accepted write
//       rd_en  : read request, one nibble per cycle, ignored while empty
//       dout   : registered read nibble, holds when no read is accepted
//       full   : no room for another whole word
//       empty  : no nibble available
module fifo_generator
   import fifo_generator_pkg::*;
#(
   parameter int unsigned DIN_W  = DIN_W_DEF,
   parameter int unsigned DOUT_W = DOUT_W_DEF,
   parameter int unsigned DEPTH  = DEPTH_DEF
) (
   input  logic              wr_clk,
   input  logic              rd_clk,
   input  logic              rst,
   input  logic              wr_en,
   input  logic [DIN_W-1:0]  din,
   output logic              wr_ack,
   input  logic              rd_en,
   output logic [DOUT_W-1:0] dout,
   output logic              full,
   output logic              empty
);

   localparam int unsigned PTR_W = nib_ptr_w(DEPTH);
   localparam int unsigned WA_W  = PTR_W - 1;
   localparam int unsigned CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_THR = CNT_W'(2 * DEPTH - 2);

   logic unused_rd_clk;
   assign unused_rd_clk = rd_clk;

   // The write pointer always sits on an even nibble, so only its word part
   // is kept; nibble address = {wptr_q, 1'b0}.
   logic [WA_W-1:0]  wptr_q,   wptr_d;
   logic [PTR_W-1:0] rptr_q,   rptr_d;
   logic [CNT_W-1:0] count_q,  count_d;
   logic             wr_ack_q, wr_ack_d;
   logic             empty_q,  empty_d;
   logic             full_q,   full_d;
   logic             wr_acc;
   logic             rd_acc;

   always_comb begin
      wr_acc   = wr_en && !full_q && !rst;
      rd_acc   = rd_en && !empty_q && !rst;
      wptr_d   = wptr_q + (wr_acc ? WA_W'(1) : WA_W'(0));
      rptr_d   = rptr_q + (rd_acc ? PTR_W'(1) : PTR_W'(0));
      count_d  = count_q + (wr_acc ? CNT_W'(2) : CNT_W'(0))
                         - (rd_acc ? CNT_W'(1) : CNT_W'(0));
      // Flags are computed from the post-edge occupancy so they are correct
      // in the same cycle the pointers move.
      empty_d  = (count_d == '0);
      full_d   = (count_d > FULL_THR);
      wr_ack_d = wr_acc;
   end

   always_ff @(posedge wr_clk) begin
      if (rst) begin
         wptr_q   <= '0;
         rptr_q   <= '0;
         count_q  <= '0;
         wr_ack_q <= 1'b0;
         empty_q  <= 1'b1;
         full_q   <= 1'b0;
      end else begin
         wptr_q   <= wptr_d;
         rptr_q   <= rptr_d;
         count_q  <= count_d;
         wr_ack_q <= wr_ack_d;
         empty_q  <= empty_d;
         full_q   <= full_d;
      end
   end

   fifo_generator_ram #(
      .DOUT_W (DOUT_W),
      .DEPTH  (DEPTH)
   ) u_ram (
      .clk      (wr_clk),
      .rst      (rst),
      .we       (wr_acc),
      .waddr    (wptr_q),
      .wdata_hi (din[DIN_W-1:DOUT_W]),
      .wdata_lo (din[DOUT_W-1:0]),
      .re       (rd_acc),
      .raddr    (rptr_q),
      .rdata    (dout)
   );

   assign wr_ack = wr_ack_q;
   assign empty  = empty_q;
   assign full   = full_q;

endmodule

// File: tb/tb_fifo_generator.sv
// tb_fifo_generator
//    Directed stimulus with a nibble scoreboard: the driver pushes the
//    expected nibble for every read it expects to be accepted, and a
//    separate monitor pops and compares dout after every clock edge.
module tb_fifo_generator;

   logic       wr_clk = 1'b0;
   logic       rst    = 1'b1;
   logic       wr_en  = 1'b0;
   logic [5:0] din    = '0;
   logic       rd_en  = 1'b0;
   logic       wr_ack;
   logic [2:0] dout;
   logic       full;
   logic       empty;

   always #5 wr_clk = ~wr_clk;

   fifo_generator #(
      .DIN_W  (6),
      .DOUT_W (3),
      .DEPTH  (16)
   ) dut (
      .wr_clk (wr_clk),
      .rd_clk (wr_clk),
      .rst    (rst),
      .wr_en  (wr_en),
      .din    (din),
      .wr_ack (wr_ack),
      .rd_en  (rd_en),
      .dout   (dout),
      .full   (full),
      .empty  (empty)
   );

   int checks = 0;
   int errors = 0;

   logic [2:0] m_q   [$];   // model storage
   logic [2:0] exp_q [$];   // scoreboard: nibbles due on dout
   int         m_count = 0;
   bit         m_empty = 1'b1;
   bit         m_full  = 1'b0;
   bit         m_ack   = 1'b0;
   bit         pend_rd  = 1'b0;
   bit         pend_rst = 1'b1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
      end
   endtask

   // One clock cycle of stimulus plus model update and flag checks.
   task automatic cycle(input bit w, input logic [5:0] d, input bit r, input bit rs);
      bit aw, ar;
      @(negedge wr_clk);
      wr_en = w;
      din   = d;
      rd_en = r;
      rst   = rs;
      if (rs) begin
         m_q.delete();
         exp_q.delete();
         m_count  = 0;
         m_empty  = 1'b1;
         m_full   = 1'b0;
         m_ack    = 1'b0;
         pend_rd  = 1'b0;
         pend_rst = 1'b1;
      end else begin
         aw = w && !m_full;
         ar = r && !m_empty;
         pend_rst = 1'b0;
         pend_rd  = ar;
         if (ar) exp_q.push_back(m_q.pop_front());
         if (aw) begin
            m_q.push_back(d[5:3]);
            m_q.push_back(d[2:0]);
         end
         m_count = m_count + (aw ? 2 : 0) - (ar ? 1 : 0);
         m_empty = (m_count == 0);
         m_full  = (m_count > 30);
         m_ack   = aw;
      end
      @(posedge wr_clk);
      #1;
      chk("wr_ack", 32'(wr_ack), 32'(m_ack));
      chk("empty",  32'(empty),  32'(m_empty));
      chk("full",   32'(full),   32'(m_full));
   endtask

   // Monitor: dout must show the popped nibble after an accepted read and
   // hold otherwise; reset forces it to zero.
   initial begin
      bit         pr, ps;
      logic [2:0] exp_dout;
      exp_dout = '0;
      forever begin
         @(posedge wr_clk);
         pr = pend_rd;
         ps = pend_rst;
         #1;
         if (ps) begin
            exp_dout = '0;
         end else if (pr) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL scoreboard_underflow actual=empty required=entry at %0t", $time);
            end else begin
               exp_dout = exp_q.pop_front();
            end
         end
         chk("dout_mon", 32'(dout), 32'(exp_dout));
      end
   end

   initial begin
      logic [5:0] wd;
      logic [2:0] wrap_exp [10];
      wrap_exp = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1, 3'd3};

      // Reset
      cycle(1'b0, 6'd0, 1'b0, 1'b1);
      cycle(1'b0, 6'd0, 1'b0, 1'b1);
      chk("rst_dout", 32'(dout), 32'd0);
      chk("rst_empty", 32'(empty), 32'd1);

      // Single word, two nibbles out MSB first
      cycle(1'b1, 6'b101_011, 1'b0, 1'b0);
      chk("t1_ack", 32'(wr_ack), 32'd1);
      chk("t1_empty", 32'(empty), 32'd0);
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
      chk("t1_nib0", 32'(dout), 32'b101);
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
      chk("t1_nib1", 32'(dout), 32'b011);
      chk("t1_empty_after", 32'(empty), 32'd1);

      // Read while empty holds dout
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
      chk("empty_rd_hold", 32'(dout), 32'b011);
      chk("empty_rd_flag", 32'(empty), 32'd1);

      // Fill 16 words, drop a 17th, drain 32 nibbles
      for (int i = 0; i < 16; i++) cycle(1'b1, 6'(i), 1'b0, 1'b0);
      chk("fill_full", 32'(full), 32'd1);
      cycle(1'b1, 6'h3F, 1'b0, 1'b0);
      chk("overflow_ack", 32'(wr_ack), 32'd0);
      for (int i = 0; i < 32; i++) begin
         cycle(1'b0, 6'd0, 1'b1, 1'b0);
         wd = 6'(i / 2);
         chk("drain_nib", 32'(dout), (i % 2 == 1) ? 32'(wd[2:0]) : 32'(wd[5:3]));
         if (i == 0) chk("full_after_1rd", 32'(full), 32'd1);
         if (i == 1) chk("full_after_2rd", 32'(full), 32'd0);
      end
      chk("drain_empty", 32'(empty), 32'd1);

      // Move pointers to nibble 30, then cross the wrap with concurrent traffic
      for (int i = 0; i < 14; i++) cycle(1'b1, 6'(i + 20), 1'b0, 1'b0);
      for (int i = 0; i < 28; i++) cycle(1'b0, 6'd0, 1'b1, 1'b0);
      cycle(1'b1, 6'o12, 1'b0, 1'b0);
      cycle(1'b1, 6'o34, 1'b0, 1'b0);
      cycle(1'b1, 6'o56, 1'b1, 1'b0);
      chk("wrap_rw0", 32'(dout), 32'(wrap_exp[0]));
      cycle(1'b1, 6'o70, 1'b1, 1'b0);
      chk("wrap_rw1", 32'(dout), 32'(wrap_exp[1]));
      cycle(1'b1, 6'o13, 1'b1, 1'b0);
      chk("wrap_rw2", 32'(dout), 32'(wrap_exp[2]));
      for (int i = 3; i < 10; i++) begin
         cycle(1'b0, 6'd0, 1'b1, 1'b0);
         chk("wrap_drain", 32'(dout), 32'(wrap_exp[i]));
      end
      chk("wrap_empty", 32'(empty), 32'd1);

      // Reset mid-operation overrides wr_en/rd_en and discards contents
      for (int i = 0; i < 5; i++) cycle(1'b1, 6'(i + 1), 1'b0, 1'b0);
      cycle(1'b1, 6'o77, 1'b1, 1'b1);
      chk("mid_rst_empty", 32'(empty), 32'd1);
      chk("mid_rst_full", 32'(full), 32'd0);
      chk("mid_rst_dout", 32'(dout), 32'd0);
      chk("mid_rst_ack", 32'(wr_ack), 32'd0);
      cycle(1'b1, 6'o52, 1'b0, 1'b0);
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
      chk("post_rst_nib0", 32'(dout), 32'd5);
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
      chk("post_rst_nib1", 32'(dout), 32'd2);
      chk("post_rst_empty", 32'(empty), 32'd1);

      // Clock-counter pattern: one word, rd_en held for three cycles
      cycle(1'b1, 6'o74, 1'b0, 1'b0);
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
      chk("cc_nib0", 32'(dout), 32'd7);
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
      chk("cc_nib1", 32'(dout), 32'd4);
      cycle(1'b0, 6'd0, 1'b1, 1'b0);
      chk("cc_third_ignored", 32'(dout), 32'd4);
      chk("cc_empty", 32'(empty), 32'd1);

      cycle(1'b0, 6'd0, 1'b0, 1'b0);
      #2;
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
